// File: rtl/flash_spi_reader_if.sv
// Request/response bus between a flash client (master) and the SPI-NOR read controller (slave).
// Addresses and requests flow toward the controller; bytes, strobes and busy flow back.
interface flash_spi_reader_if;
    logic [23:0] flash_addr;
    logic        request_read_addr;
    logic        request_read_next;
    logic        d_ready;
    logic [7:0]  d_out;
    logic        busy;

    modport master (
        output flash_addr, request_read_addr, request_read_next,
        input  d_ready, d_out, busy
    );

    modport slave (
        input  flash_addr, request_read_addr, request_read_next,
        output d_ready, d_out, busy
    );
endinterface

// File: rtl/flash_spi_reader.sv
// SPI-NOR read controller: wakes the flash, issues READ (0x03) + 24-bit address and streams
// bytes back one per request, keeping CS low between sequential requests.
module flash_spi_reader #(
    parameter int CLK_DIV        = 1,
    parameter int INIT_CYCLES    = 8192,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    flash_spi_reader_if.slave bus,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [7:0]  WAKE_CMD  = 8'hAB;
    localparam logic [7:0]  READ_CMD  = 8'h03;
    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [31:0] INIT_LAST = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] CSH_LAST  = 32'(CS_HIGH_CYCLES - 1);

    typedef enum logic [3:0] {
        S_INIT,
        S_WAKE,
        S_GUARD,
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DATA_END,
        S_RESP,
        S_STREAM,
        S_GUARD_RE
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_cnt, w_cnt_next;
    logic [7:0]  r_div, w_div_next;
    logic [5:0]  r_bit, w_bit_next;
    logic [31:0] r_tx, w_tx_next;
    logic [7:0]  r_rx, w_rx_next;
    logic [23:0] r_addr, w_addr_next;
    logic        r_cs_n, w_cs_n_next;
    logic        r_sclk, w_sclk_next;
    logic        r_mosi, w_mosi_next;
    logic [7:0]  r_d_out, w_d_out_next;
    logic        r_d_ready, w_d_ready_next;

    logic        w_shifting;
    logic        w_half_end;
    logic        w_rise;
    logic        w_fall;
    logic        w_last_bit;
    logic        w_accept;
    logic [23:0] w_cmd_addr;

    // SCLK only runs while a shift is in progress; each edge is a registered toggle.
    assign w_shifting = (r_state == S_WAKE) || (r_state == S_CMD) || (r_state == S_DATA);
    assign w_half_end = (r_div == DIV_LAST);
    assign w_rise     = w_shifting && w_half_end && !r_sclk;
    assign w_fall     = w_shifting && w_half_end && r_sclk;
    assign w_last_bit = (r_state == S_CMD) ? (r_bit == 6'd31) : (r_bit == 6'd7);
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_STREAM)) && !r_d_ready;
    assign w_cmd_addr = (r_state == S_IDLE) ? bus.flash_addr : r_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_addr    <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_d_out   <= '0;
            r_d_ready <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_div     <= w_div_next;
            r_bit     <= w_bit_next;
            r_tx      <= w_tx_next;
            r_rx      <= w_rx_next;
            r_addr    <= w_addr_next;
            r_cs_n    <= w_cs_n_next;
            r_sclk    <= w_sclk_next;
            r_mosi    <= w_mosi_next;
            r_d_out   <= w_d_out_next;
            r_d_ready <= w_d_ready_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_div_next     = r_div;
        w_bit_next     = r_bit;
        w_tx_next      = r_tx;
        w_rx_next      = r_rx;
        w_addr_next    = r_addr;
        w_cs_n_next    = r_cs_n;
        w_sclk_next    = r_sclk;
        w_mosi_next    = r_mosi;
        w_d_out_next   = r_d_out;
        w_d_ready_next = 1'b0;

        if (w_shifting) begin
            w_div_next = w_half_end ? 8'd0 : r_div + 8'd1;
            if (w_half_end) begin
                w_sclk_next = ~r_sclk;
            end
        end
        if (w_rise && (r_state == S_DATA)) begin
            w_rx_next = {r_rx[6:0], spi_miso};
        end
        // MOSI advances on the falling edge so it is stable across the next rising edge.
        if (w_fall && !w_last_bit) begin
            w_bit_next = r_bit + 6'd1;
            if (r_state != S_DATA) begin
                w_tx_next   = {r_tx[30:0], 1'b0};
                w_mosi_next = r_tx[30];
            end
        end

        case (r_state)
            S_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_state_next = S_WAKE;
                    w_cs_n_next  = 1'b0;
                    w_tx_next    = {WAKE_CMD, 24'h000000};
                    w_mosi_next  = WAKE_CMD[7];
                    w_bit_next   = '0;
                    w_div_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_WAKE: begin
                if (w_fall && w_last_bit) begin
                    w_state_next = S_GUARD;
                    w_cs_n_next  = 1'b1;
                    w_mosi_next  = 1'b0;
                    w_cnt_next   = '0;
                end
            end
            S_GUARD: begin
                if (r_cnt == CSH_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_IDLE, S_GUARD_RE: begin
                if ((r_state == S_IDLE && bus.request_read_addr) ||
                    (r_state == S_GUARD_RE && r_cnt == CSH_LAST)) begin
                    w_state_next = S_CMD;
                    w_addr_next  = w_cmd_addr;
                    w_cs_n_next  = 1'b0;
                    w_tx_next    = {READ_CMD, w_cmd_addr};
                    w_mosi_next  = READ_CMD[7];
                    w_bit_next   = '0;
                    w_div_next   = '0;
                    w_sclk_next  = 1'b0;
                end else if (r_state == S_GUARD_RE) begin
                    w_cnt_next = r_cnt + 32'd1;
                end
            end
            S_CMD: begin
                if (w_fall && w_last_bit) begin
                    w_state_next = S_DATA;
                    w_mosi_next  = 1'b0;
                    w_tx_next    = '0;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_fall && w_last_bit) begin
                    w_state_next = S_DATA_END;
                end
            end
            S_DATA_END: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_d_out_next   = r_rx;
                w_d_ready_next = 1'b1;
                w_state_next   = S_STREAM;
            end
            S_STREAM: begin
                // A new address wins over a simultaneous next-byte request.
                if (w_accept && bus.request_read_addr) begin
                    w_state_next = S_GUARD_RE;
                    w_addr_next  = bus.flash_addr;
                    w_cs_n_next  = 1'b1;
                    w_cnt_next   = '0;
                end else if (w_accept && bus.request_read_next) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                    w_div_next   = '0;
                end
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    assign spi_cs_n    = r_cs_n;
    assign spi_sclk    = r_sclk;
    assign spi_mosi    = r_mosi;
    assign bus.d_ready = r_d_ready;
    assign bus.d_out   = r_d_out;
    assign bus.busy    = !w_accept;

endmodule

// File: tb/tb_flash_spi_reader.sv
// Bench for flash_spi_reader: two instances (CLK_DIV=1 and 3) against a behavioural SPI-NOR model
// that decodes the serial command and serves byte (addr & 0xFF) ^ 0x5A.
module tb_flash_spi_reader;

    localparam int INIT = 16;
    localparam int CSH  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   req_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    flash_spi_reader_if bus0 ();
    flash_spi_reader_if bus1 ();

    wire [1:0]  cs_w;
    wire [1:0]  sclk_w;
    wire [1:0]  mosi_w;
    wire [1:0]  miso_w;
    wire [1:0]  drdy_w = {bus1.d_ready, bus0.d_ready};
    wire [1:0]  busy_w = {bus1.busy, bus0.busy};
    wire [15:0] dout_w = {bus1.d_out, bus0.d_out};

    flash_spi_reader #(.CLK_DIV(1), .INIT_CYCLES(INIT), .CS_HIGH_CYCLES(CSH)) dut0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus0),
        .spi_cs_n (cs_w[0]),
        .spi_sclk (sclk_w[0]),
        .spi_mosi (mosi_w[0]),
        .spi_miso (miso_w[0])
    );

    flash_spi_reader #(.CLK_DIV(3), .INIT_CYCLES(INIT), .CS_HIGH_CYCLES(CSH)) dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus1),
        .spi_cs_n (cs_w[1]),
        .spi_sclk (sclk_w[1]),
        .spi_mosi (mosi_w[1]),
        .spi_miso (miso_w[1])
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Behavioural flash: counts SCLK rising edges per CS window, captures the first 32 MOSI bits,
    // and after a READ command presents data bits on falling edges from a wrapping 24-bit address.
    for (genvar gi = 0; gi < 2; gi++) begin : fl
        int          bits = 0;
        logic [31:0] shin = '0;
        logic [31:0] cmd = '0;
        int          windows = 0;
        int          win_bits = 0;
        logic [31:0] win_word = '0;
        int          drdy_cnt = 0;
        int          cs_high_run = 0;
        int          last_cs_high = 0;
        logic        miso_r = 1'b0;

        assign miso_w[gi] = miso_r;

        always @(negedge cs_w[gi]) begin
            bits = 0;
            shin = '0;
        end

        always @(posedge cs_w[gi]) begin
            windows++;
            win_bits = bits;
            win_word = shin;
        end

        always @(posedge sclk_w[gi]) begin
            if (cs_w[gi] == 1'b0) begin
                if (bits < 32) shin = {shin[30:0], mosi_w[gi]};
                bits++;
                if (bits == 32) cmd = shin;
            end
        end

        always @(negedge sclk_w[gi]) begin : serve
            int          k;
            logic [23:0] a;
            logic [7:0]  b;
            if (cs_w[gi] == 1'b0 && bits >= 32 && cmd[31:24] == 8'h03) begin
                k = bits - 32;
                a = cmd[23:0] + 24'(k / 8);
                b = flash_byte(a);
                miso_r = b[7 - (k % 8)];
            end
        end

        always @(posedge clk) begin
            if (drdy_w[gi]) drdy_cnt++;
            if (cs_w[gi] == 1'b1) begin
                cs_high_run++;
            end else begin
                if (cs_high_run != 0) last_cs_high = cs_high_run;
                cs_high_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int idx, input bit a, input bit n, input logic [23:0] addr);
        if (idx == 0) begin
            bus0.flash_addr = addr;
            bus0.request_read_addr = a;
            bus0.request_read_next = n;
        end else begin
            bus1.flash_addr = addr;
            bus1.request_read_addr = a;
            bus1.request_read_next = n;
        end
        @(posedge clk);
        #1;
        req_cyc = cyc;
        bus0.request_read_addr = 1'b0;
        bus0.request_read_next = 1'b0;
        bus1.request_read_addr = 1'b0;
        bus1.request_read_next = 1'b0;
    endtask

    task automatic wait_dready(input int idx, input int bound, output int lat, output logic [7:0] d);
        lat = -1;
        d = 8'h00;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (drdy_w[idx]) begin
                lat = cyc - req_cyc;
                d = dout_w[idx*8 +: 8];
                break;
            end
        end
    endtask

    task automatic wait_idle(input int idx, input int bound, output int n);
        n = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (!busy_w[idx]) begin
                n = i + 1;
                break;
            end
        end
    endtask

    task automatic read_step(input int idx, input bit a_flag, input bit n_flag,
                             input logic [23:0] addr, input int exp_lat,
                             input logic [23:0] data_addr, input string tag);
        int         lat;
        logic [7:0] d;
        pulse(idx, a_flag, n_flag, addr);
        wait_dready(idx, exp_lat + 50, lat, d);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, {24'h0, d}, {24'h0, flash_byte(data_addr)});
        if (a_flag) check({tag, "_cmd"}, (idx == 0) ? fl[0].cmd : fl[1].cmd, {8'h03, addr});
        $display("read inst=%0d %s addr=%06h data=%02h latency=%0d", idx, tag, data_addr, d, lat);
        @(posedge clk);
        #1;
        check({tag, "_pulse_width"}, {31'h0, drdy_w[idx]}, 32'h0);
        check({tag, "_busy_stream"}, {31'h0, busy_w[idx]}, 32'h0);
    endtask

    initial begin
        int          n;
        int          w0;
        int          d0;
        int          rc;
        int          lat;
        int          len;
        int          gap;
        bit          found;
        logic [7:0]  d;
        logic [23:0] cur;

        bus0.flash_addr = '0;
        bus0.request_read_addr = 1'b0;
        bus0.request_read_next = 1'b0;
        bus1.flash_addr = '0;
        bus1.request_read_addr = 1'b0;
        bus1.request_read_next = 1'b0;

        // Reset state
        reset_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_cs_n", {31'h0, cs_w[0]}, 32'h1);
        check("rst_sclk", {31'h0, sclk_w[0]}, 32'h0);
        check("rst_mosi", {31'h0, mosi_w[0]}, 32'h0);
        check("rst_d_ready", {31'h0, drdy_w[0]}, 32'h0);
        check("rst_d_out", {24'h0, dout_w[7:0]}, 32'h0);
        check("rst_busy", {31'h0, busy_w[0]}, 32'h1);
        check("rst_busy_inst1", {31'h0, busy_w[1]}, 32'h1);

        // Init + wake: one CS window carrying 0xAB, then the CS-high guard before busy drops
        w0 = fl[0].windows;
        d0 = fl[0].drdy_cnt;
        reset_n = 1'b1;
        wait_idle(0, 2000, n);
        $display("init inst=0 busy_fall_after=%0d", n);
        check("init_busy_fall", n, INIT + 16 + CSH);
        check("wake_windows", fl[0].windows - w0, 1);
        check("wake_bits", fl[0].win_bits, 8);
        check("wake_word", fl[0].win_word, 32'hAB);
        check("wake_guard_len", fl[0].cs_high_run, CSH);
        check("init_no_dready", fl[0].drdy_cnt - d0, 0);

        // request_read_next in IDLE is ignored
        w0 = fl[0].windows;
        d0 = fl[0].drdy_cnt;
        pulse(0, 1'b0, 1'b1, 24'($urandom));
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        $display("idle_next inst=0 ignored");
        check("idle_next_no_dready", fl[0].drdy_cnt - d0, 0);
        check("idle_next_cs", {31'h0, cs_w[0]}, 32'h1);
        check("idle_next_busy", {31'h0, busy_w[0]}, 32'h0);

        // Single read and sequential stream
        cur = 24'hA1B200;
        read_step(0, 1'b1, 1'b0, cur, 82, cur, "single");
        w0 = fl[0].windows;
        for (int k = 0; k < 7; k++) begin
            cur = cur + 24'd1;
            read_step(0, 1'b0, 1'b1, 24'h0, 18, cur, "stream");
        end
        check("stream_cs_held", fl[0].windows - w0, 0);

        // Requests while busy are dropped
        cur = cur + 24'd1;
        d0 = fl[0].drdy_cnt;
        pulse(0, 1'b0, 1'b1, 24'h0);
        rc = req_cyc;
        pulse(0, 1'b1, 1'b1, 24'($urandom));
        req_cyc = rc;
        wait_dready(0, 80, lat, d);
        $display("busy_drop inst=0 addr=%06h data=%02h latency=%0d", cur, d, lat);
        check("busy_drop_latency", lat, 18);
        check("busy_drop_data", {24'h0, d}, {24'h0, flash_byte(cur)});
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("busy_drop_single_dready", fl[0].drdy_cnt - d0, 1);
        check("busy_drop_cs_held", fl[0].windows - w0, 0);

        // Both requests together in STREAM: address wins, CS high for the guard, new command
        cur = 24'($urandom);
        read_step(0, 1'b1, 1'b1, cur, CSH + 82, cur, "both_req");
        check("both_req_cs_high", fl[0].last_cs_high, CSH);

        // Random streams; the first crosses the 24-bit wrap
        for (int s = 0; s < 4; s++) begin
            cur = (s == 0) ? 24'hFFFFFE : 24'($urandom);
            len = (s == 0) ? 4 : int'($urandom_range(1, 4));
            read_step(0, 1'b1, 1'b0, cur, CSH + 82, cur, "rand_addr");
            for (int k = 1; k < len; k++) begin
                gap = int'($urandom_range(0, 5));
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
                cur = cur + 24'd1;
                read_step(0, 1'b0, 1'b1, 24'h0, 18, cur, "rand_next");
            end
        end

        // Reset during bit 20 of the command phase
        w0 = fl[0].windows;
        d0 = fl[0].drdy_cnt;
        pulse(0, 1'b1, 1'b0, 24'($urandom));
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (fl[0].windows > w0 && cs_w[0] == 1'b0 && fl[0].bits >= 20) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_reached_bit20", {31'h0, found}, 32'h1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        $display("midrst inst=0 cs_n=%0b sclk=%0b busy=%0b", cs_w[0], sclk_w[0], busy_w[0]);
        check("midrst_cs_n", {31'h0, cs_w[0]}, 32'h1);
        check("midrst_sclk", {31'h0, sclk_w[0]}, 32'h0);
        check("midrst_busy", {31'h0, busy_w[0]}, 32'h1);
        reset_n = 1'b1;
        w0 = fl[0].windows;
        wait_idle(0, 2000, n);
        check("midrst_busy_fall", n, INIT + 16 + CSH);
        check("midrst_no_dready", fl[0].drdy_cnt - d0, 0);
        check("midrst_wake_windows", fl[0].windows - w0, 1);
        check("midrst_wake_word", fl[0].win_word, 32'hAB);
        cur = 24'($urandom);
        read_step(0, 1'b1, 1'b0, cur, 82, cur, "post_reset");

        // CLK_DIV=3 instance
        wait_idle(1, 3000, n);
        check("inst1_idle", {31'h0, (n > 0)}, 32'h1);
        cur = 24'hA1B200;
        read_step(1, 1'b1, 1'b0, cur, 242, cur, "div3_single");
        cur = cur + 24'd1;
        read_step(1, 1'b0, 1'b1, 24'h0, 50, cur, "div3_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
